// File: rtl/tl_burst_rr_arbiter.sv
// N-to-1 round-robin arbiter for multi-beat TileLink messages: the grant stays on one
// requester from the first to the last beat of a message, and priority rotates only between messages.
module tl_burst_rr_arbiter #(
  parameter int N             = 4,
  parameter int DATA_W        = 64,
  parameter int SIZE_W        = 4,
  parameter int LG_BEAT_BYTES = 3,
  parameter int MAX_SIZE      = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        valid_i,
  output logic [N-1:0]        ready_o,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic [N*SIZE_W-1:0] size_i,
  input  logic [N-1:0]        has_data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                last_o,
  output logic [N-1:0]        grant_o
);

  localparam int CNT_W = MAX_SIZE - LG_BEAT_BYTES + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rrSel, sel, selNext;
  logic [SIZE_W-1:0]  selSize, clampSize;
  logic [CNT_W-1:0]   beats;
  logic               anyValid, multiBeat, fire;

  // Round-robin search starting at ptr_q, wrapping from N-1 back to 0.
  always_comb begin
    rrSel    = ptr_q;
    anyValid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!anyValid && valid_i[IDX_W'((int'(ptr_q) + i) % N)]) begin
        rrSel    = IDX_W'((int'(ptr_q) + i) % N);
        anyValid = 1'b1;
      end
    end
  end

  assign sel       = (state_q == LOCKED) ? lock_q : rrSel;
  assign selNext   = (sel == IDX_W'(N - 1)) ? '0 : sel + 1'b1;
  assign selSize   = size_i[int'(sel)*SIZE_W +: SIZE_W];
  assign clampSize = (selSize > SIZE_W'(MAX_SIZE)) ? SIZE_W'(MAX_SIZE) : selSize;
  assign multiBeat = has_data_i[sel] && (clampSize > SIZE_W'(LG_BEAT_BYTES));
  // Only meaningful when multiBeat is set; otherwise the shift amount underflows harmlessly.
  assign beats     = CNT_W'(1) << (clampSize - SIZE_W'(LG_BEAT_BYTES));

  always_comb begin
    valid_o = 1'b0;
    ready_o = '0;
    grant_o = '0;
    last_o  = 1'b0;
    data_o  = data_i[int'(sel)*DATA_W +: DATA_W];
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        valid_o = anyValid;
        last_o  = !multiBeat;
      end
      LOCKED: begin
        valid_o = valid_i[lock_q];
        last_o  = (cnt_q == CNT_W'(1));
      end
      default: ;
    endcase

    // A locked requester keeps the grant even while its valid is low.
    if (rst_n && (state_q == LOCKED || anyValid)) begin
      grant_o[sel] = 1'b1;
      ready_o[sel] = ready_i & valid_i[sel];
    end
    if (!rst_n) valid_o = 1'b0;
    fire = valid_o & ready_i;

    if (fire) begin
      case (state_q)
        IDLE: begin
          if (multiBeat) begin
            lock_d  = sel;
            cnt_d   = beats - CNT_W'(1);
            state_d = LOCKED;
          end else begin
            ptr_d = selNext;
          end
        end
        LOCKED: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            ptr_d   = selNext;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
